// File: rtl/util_reset_gen.sv
// Reset-request transmitter: drives rst_out into a remote domain and tracks its
// synchronized acknowledge. Optional request latching: UTIL_RESET_GEN_REQ_LATCH_EN.
module util_reset_gen #(
  parameter int PULSE_LEN = 16,
  parameter int TIMEOUT   = 1024,
  parameter int ACK_SYNC  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack_in,
  output logic rst_out,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PL_M1 = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ACK_SYNC-1:0]  ack_sync_q, ack_sync_d;
  logic                 to_flag_q, to_flag_d;
  logic                 rst_out_q, rst_out_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ack_s;
  logic                 fin;
  logic                 tmo;
  logic                 restart;

`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
  logic                 pending_q, pending_d;
  logic                 pend_now;
`endif

  assign ack_s = ack_sync_q[ACK_SYNC-1];

  always_comb begin
    ack_sync_d = {ack_sync_q[ACK_SYNC-2:0], ack_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_flag_d  = to_flag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fin        = 1'b0;
    tmo        = 1'b0;
    restart    = 1'b0;
`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
    // A request on the completing cycle merges into the pending slot too.
    pend_now   = pending_q | (req & (state_q != S_IDLE));
    pending_d  = pend_now;
    restart    = pend_now;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        cnt_d = cnt_q + CW'(1);
        // Normal exit takes priority over a coincident timeout.
        if ((cnt_q >= PL_M1) && ack_s) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == TO_M1) begin
          to_flag_d = 1'b1;
          state_d   = S_RELEASE;
          cnt_d     = '0;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q + CW'(1);
        if (!ack_s) begin
          fin = 1'b1;
        end else if (cnt_q == TO_M1) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
        if (fin) begin
          done_d    = 1'b1;
          err_d     = to_flag_q | tmo;
          to_flag_d = 1'b0;
          cnt_d     = '0;
          state_d   = restart ? S_ASSERT : S_IDLE;
`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
          pending_d = 1'b0;
`endif
        end
      end
      default: begin
        // Unreachable encoding: recover by re-resetting the remote side.
        state_d   = S_ASSERT;
        cnt_d     = '0;
        to_flag_d = 1'b0;
      end
    endcase

    rst_out_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      ack_sync_q <= '0;
      to_flag_q  <= 1'b0;
      rst_out_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_sync_q <= ack_sync_d;
      to_flag_q  <= to_flag_d;
      rst_out_q  <= rst_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end
`endif

  assign rst_out = rst_out_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_util_reset_gen.sv
// Randomized + directed bench for util_reset_gen against a timestamp/queue
// reference model and transaction-level pulse measurements.
module tb_util_reset_gen;
  localparam int PULSE_LEN = 16;
  localparam int TIMEOUT   = 64;
  localparam int ACK_SYNC  = 3;

  logic clk = 1'b0;
  logic rst, req;
  logic ack_in, rst_out, busy, done, err;
  logic [1:0] ack_mode;          // 0 loopback, 1 stuck low, 2 stuck high
  logic [2:0] rem_q = '0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  util_reset_gen #(.PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .ACK_SYNC(ACK_SYNC)) dut (
    .clk(clk), .rst(rst), .req(req), .ack_in(ack_in),
    .rst_out(rst_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Remote domain: plain 3-flop synchronizer of rst_out.
  always @(posedge clk) rem_q <= {rem_q[1:0], rst_out};
  assign ack_in = (ack_mode == 2'd0) ? rem_q[2] : (ack_mode == 2'd2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: phases with entry timestamps, ack delay line as a queue.
  int ecount = 0;
  int m_phase, m_entry;
  bit m_to, m_pend;
  bit ack_line[$];
  bit exp_rst_out, exp_busy, exp_done, exp_err;

  always @(posedge clk) begin
    bit a, pnow;
    int held;
    if (rst) begin
      m_phase = 1; m_entry = ecount + 1; m_to = 0; m_pend = 0;
      ack_line = '{1'b0, 1'b0, 1'b0};
      exp_done = 0; exp_err = 0;
    end else begin
      a = ack_line.pop_front();
      ack_line.push_back(ack_in);
      held = ecount - m_entry + 1;   // cycles spent in this phase including this one
      exp_done = 0; exp_err = 0;
      pnow = m_pend;
`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
      if (m_phase != 0 && req) pnow = 1;
`endif
      case (m_phase)
        0: if (req) begin m_phase = 1; m_entry = ecount + 1; end
        1: begin
          if (held >= PULSE_LEN && a) begin
            m_phase = 2; m_entry = ecount + 1;
          end else if (held == TIMEOUT) begin
            m_to = 1; m_phase = 2; m_entry = ecount + 1;
          end
        end
        default: begin
          if (!a || held == TIMEOUT) begin
            exp_done = 1;
            exp_err  = m_to || a;
            m_to     = 0;
            m_phase  = pnow ? 1 : 0;
            pnow     = 0;
            m_entry  = ecount + 1;
          end
        end
      endcase
      m_pend = pnow;
    end
    exp_rst_out = (m_phase == 1);
    exp_busy    = (m_phase != 0);
    ecount++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rst_out", rst_out, exp_rst_out);
      chk("busy",    busy,    exp_busy);
      chk("done",    done,    exp_done);
      chk("err",     err,     exp_err);
    end
  end

  // Transaction monitor on pre-edge values: pulse lengths, done/err counts, fall-to-done gap.
  int run = 0, mcyc = 0, fall_edge = 0, gap = 0;
  int n_done = 0, n_err = 0, n_err_alone = 0;
  int pulses[$];

  always @(posedge clk) begin
    if (rst) run = 0;
    else begin
      if (rst_out) run++;
      else if (run != 0) begin pulses.push_back(run); run = 0; fall_edge = mcyc; end
      if (done) begin n_done++; gap = mcyc - fall_edge; if (err) n_err++; end
      else if (err) n_err_alone++;
    end
    mcyc++;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    n_done = 0; n_err = 0; n_err_alone = 0; pulses.delete();
  endtask

  function automatic int last_pulse();
    return (pulses.size() == 0) ? -1 : pulses[pulses.size()-1];
  endfunction

  task automatic wait_ndone(input string tag, input int target, input int max);
    int i = 0;
    while (n_done < target && i < max) begin tick(); i++; end
    chk(tag, n_done, target);
  endtask

  task automatic pulse_req();
    req = 1'b1; tick(); req = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    ack_mode = m;
    repeat (6) tick();
  endtask

  int rst_left;

  initial begin
    rst = 1'b0; req = 1'b0; ack_mode = 2'd0;
    #1 rst = 1'b1;
    #1 chk("por_async", rst_out, 1);
    repeat (5) @(posedge clk);
    chk_en = 1;
    tick();
    clr();
    rst = 1'b0;

    // Power-on: 16 edges of ASSERT after rst, one clean done, no err.
    wait_ndone("por_done", 1, 200);
    chk("por_pulse", last_pulse(), PULSE_LEN);
    chk("por_err", n_err + n_err_alone, 0);
    chk("por_busy", busy, 0);

    // Normal request with loopback remote.
    repeat (10) tick();
    clr();
    pulse_req();
    wait_ndone("req_done", 1, 200);
    chk("req_pulse", last_pulse(), PULSE_LEN);
    chk("req_err", n_err + n_err_alone, 0);

    // Stuck-low ack: ASSERT times out, RELEASE exits on its first cycle.
    set_mode(2'd1);
    clr();
    pulse_req();
    wait_ndone("lo_done", 1, 300);
    chk("lo_pulse", last_pulse(), TIMEOUT);
    chk("lo_gap", gap, 1);
    chk("lo_err", n_err, 1);
    chk("lo_err_alone", n_err_alone, 0);

    // Stuck-high ack: normal ASSERT, RELEASE times out.
    set_mode(2'd2);
    clr();
    pulse_req();
    wait_ndone("hi_done", 1, 300);
    chk("hi_pulse", last_pulse(), PULSE_LEN);
    chk("hi_gap", gap, TIMEOUT);
    chk("hi_err", n_err, 1);
    chk("hi_busy", busy, 0);

    // Second request five cycles into the first transaction.
    set_mode(2'd0);
    repeat (4) tick();
    clr();
    pulse_req();
    repeat (4) tick();
    pulse_req();
`ifdef UTIL_RESET_GEN_REQ_LATCH_EN
    wait_ndone("bb_done", 2, 300);
    repeat (40) tick();
    chk("bb_ndone", n_done, 2);
    chk("bb_npulse", pulses.size(), 2);
    chk("bb_pulse2", last_pulse(), PULSE_LEN);
`else
    wait_ndone("bb_done", 1, 300);
    repeat (40) tick();
    chk("bb_ndone", n_done, 1);
    chk("bb_npulse", pulses.size(), 1);
`endif
    chk("bb_err", n_err + n_err_alone, 0);

    // Reset while in RELEASE: aborted transaction gives no done.
    pulse_req();
    begin
      int i = 0;
      while (!(busy && !rst_out) && i < 200) begin tick(); i++; end
      chk("mid_reach_release", busy && !rst_out, 1);
    end
    #1 rst = 1'b1;
    #1 chk("mid_async", rst_out, 1);
    clr();
    tick(); tick();
    rst = 1'b0;
    wait_ndone("mid_done", 1, 200);
    repeat (30) tick();
    chk("mid_ndone", n_done, 1);
    chk("mid_pulse", last_pulse(), PULSE_LEN);

    // Random traffic: requests, ack mode changes and resets, checked cycle by cycle.
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        req = 1'b0;
        #1 rst = 1'b1;
        #1 chk("rnd_async", rst_out, 1);
        rst_left = $urandom_range(1, 3);
      end
      if (rst_left == 0) req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) ack_mode = 2'($urandom_range(0, 2));
    end
    req = 1'b0; rst = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
